atm_dispense_ctrl: RTL
======================

# atm_dispense_ctrl

Cash-dispense sequencer for the ATM. Once a withdrawal is authorised, it takes the requested amount and plans a note breakdown against the current cassette inventory. It then drives the note mechanism one note at a time over a req/ack handshake and reports done or fail to the ATM top-level FSM.

## Interface
- AMT_W, 14: amount width; matches the ATM cash bus.
- CNT_W, 8: per-cassette note-count width.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a withdrawal; sampled only in IDLE.
- amount  in  AMT_W  requested amount; captured with start.
- cancel  in  1  abort; honoured only in PLAN.
- refill  in  1  load all three cassettes with refill_cnt; IDLE only.
- refill_cnt  in  CNT_W  note count per cassette on refill.
- note_req  out  1  request one note from the mechanism.
- note_sel  out  2  denomination: 0 = 10, 1 = 20, 2 = 50.
- note_ack  in  1  mechanism has delivered the note.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on success.
- fail  out  1  one-cycle pulse on failure.
- dispensed  out  AMT_W  running total delivered; holds until the next accepted start.
- state_display  out  3  encoded FSM state.

## Operation
- States and encodings: IDLE = 0, PLAN = 1, ISSUE = 2, GAP = 3, DONE = 4, FAIL = 5.
- IDLE:
  - refill sets inv50, inv20 and inv10 to refill_cnt.
  - start is ignored in the same cycle as refill (refill wins).
  - start with amount == 0 goes to FAIL.
  - Any other start captures amount into rem, clears dispensed and the plan counts p50/p20/p10, copies inventory into shadow counts, and goes to PLAN.
- PLAN, one decision per cycle:
  - cancel goes to FAIL (highest priority).
  - rem == 0 goes to ISSUE.
  - Otherwise take the largest denomination d with shadow_d > 0 and d ≤ rem: rem -= d, shadow_d--, p_d++.
  - If no denomination qualifies, go to FAIL.
  - The plan is greedy by design: 60 against one 50, three 20s and no 10s fails.
  - Real inventory is untouched in PLAN.
- ISSUE:
  - note_req = 1; note_sel = highest denomination with p_d > 0 (order 50, 20, 10).
  - note_req and note_sel stay stable until note_ack is sampled high.
  - On note_ack: p_d--, inv_d--, dispensed += d, go to GAP.
- GAP:
  - note_req = 0 for exactly one cycle.
  - All p_d == 0 goes to DONE; otherwise back to ISSUE.
- DONE asserts done for one cycle; FAIL asserts fail for one cycle. Both return to IDLE.
- note_ack outside ISSUE is ignored.
- cancel outside PLAN is ignored; once notes start, the plan always completes.
- start and refill outside IDLE are ignored.
- Arithmetic:
  - rem and dispensed are AMT_W bits unsigned and cannot overflow (dispensed ≤ amount).
  - Plan counts never exceed inventory, so CNT_W suffices and nothing wraps.

## Timing
- Reset values:
  - All outputs 0; state IDLE.
  - inv50/inv20/inv10 = 0, so the machine must be refilled before first use.
  - rem, plan counts and shadow counts = 0.
- rst mid-operation: immediate return to reset values at the next edge.
  - Any in-flight note_req drops.
  - Inventory is lost; a refill is required.
- start accepted at edge t: state PLAN from t+1.
- A plan of k notes takes k+1 PLAN cycles.
- Each note costs (ack wait + 1) ISSUE cycles plus 1 GAP cycle.
- done/fail pulse in the cycle the state is DONE/FAIL; busy is low in the following cycle.
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.

## Structure
- Shared package atm_pkg holds:
  - the state encoding enum (shared with state_display decoding elsewhere);
  - denomination constants DEN10/DEN20/DEN50 and NOTE_SEL encodings;
  - AMT_W.
- Natural sub-module: atm_note_planner, which holds the PLAN-phase greedy selector, shadow counts and rem register. It returns p50/p20/p10 plus plan_ok/plan_fail.
- The top holds the FSM, inventory, handshake and dispensed accumulator.

## Test plan
- refill 5; start amount 180; ack 1 cycle after each req:
  - notes 50, 50, 50, 20, 10 in that order with one GAP cycle between;
  - done pulse; dispensed = 180; inv50 = 2, inv20 = 4, inv10 = 4.
- refill 1; start 90:
  - plan takes 50, 20, 10, leaving rem 10 with nothing left;
  - fail pulse; note_req never asserted; dispensed = 0; inventory unchanged.
- start 35 after refill 5: fail after PLAN, no note_req. Also start with amount 0: fail at t+1, no PLAN cycle.
- Delay note_ack by 7 cycles on the first note:
  - note_req held high and note_sel = 2 stable for all 7 cycles;
  - dispensed stays 0 until the ack edge, then reads 50.
- cancel in the second PLAN cycle: fail, no notes. cancel during ISSUE: ignored, all notes delivered, done pulse.
- rst asserted while note_req is high mid-withdrawal:
  - next cycle all outputs 0 and state_display = 0;
  - a subsequent start 50 without refill fails.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared definitions for the ATM cash-dispense path: FSM state encoding,
// note denominations and their note_sel codes, and bus widths.
package atm_pkg;

   localparam int AMT_W = 14;
   localparam int CNT_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PLAN  = 3'd1,
      ST_ISSUE = 3'd2,
      ST_GAP   = 3'd3,
      ST_DONE  = 3'd4,
      ST_FAIL  = 3'd5
   } atm_state_t;

   localparam int unsigned DEN10 = 10;
   localparam int unsigned DEN20 = 20;
   localparam int unsigned DEN50 = 50;

   localparam logic [1:0] SEL10 = 2'd0;
   localparam logic [1:0] SEL20 = 2'd1;
   localparam logic [1:0] SEL50 = 2'd2;

endpackage

// File: rtl/atm_note_planner.sv
// Greedy note planner. On load it snapshots the amount and the cassette
// inventory; each step then commits one note (largest denomination that
// still fits and is still available in the snapshot). The resulting plan
// counts are consumed one note at a time as the mechanism delivers them.
module atm_note_planner
   import atm_pkg::*;
#(
   parameter int AMT_W = 14,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [AMT_W-1:0] amount,
   input  logic [CNT_W-1:0] inv50,
   input  logic [CNT_W-1:0] inv20,
   input  logic [CNT_W-1:0] inv10,
   input  logic             step,
   input  logic             consume,
   input  logic [1:0]       consume_sel,
   output logic [CNT_W-1:0] p50,
   output logic [CNT_W-1:0] p20,
   output logic [CNT_W-1:0] p10,
   output logic             plan_ok,
   output logic             plan_fail
);

   localparam logic [AMT_W-1:0] D10 = AMT_W'(DEN10);
   localparam logic [AMT_W-1:0] D20 = AMT_W'(DEN20);
   localparam logic [AMT_W-1:0] D50 = AMT_W'(DEN50);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [AMT_W-1:0] rem;
   logic [CNT_W-1:0] sh50, sh20, sh10;
   logic             take50, take20, take10;

   // Pick the largest denomination that fits the remainder and is still in the snapshot
   always_comb begin
      take50    = (sh50 != '0) && (rem >= D50);
      take20    = !take50 && (sh20 != '0) && (rem >= D20);
      take10    = !take50 && !take20 && (sh10 != '0) && (rem >= D10);
      plan_ok   = (rem == '0);
      plan_fail = (rem != '0) && !(take50 || take20 || take10);
   end

   // Remainder, shadow inventory and plan counts; plan counts also drain on delivery
   always_ff @(posedge clk) begin
      if (rst) begin
         rem  <= '0;
         sh50 <= '0;
         sh20 <= '0;
         sh10 <= '0;
         p50  <= '0;
         p20  <= '0;
         p10  <= '0;
      end else if (load) begin
         rem  <= amount;
         sh50 <= inv50;
         sh20 <= inv20;
         sh10 <= inv10;
         p50  <= '0;
         p20  <= '0;
         p10  <= '0;
      end else begin
         if (step) begin
            if (take50) begin
               rem  <= rem - D50;
               sh50 <= sh50 - ONE;
               p50  <= p50 + ONE;
            end else if (take20) begin
               rem  <= rem - D20;
               sh20 <= sh20 - ONE;
               p20  <= p20 + ONE;
            end else if (take10) begin
               rem  <= rem - D10;
               sh10 <= sh10 - ONE;
               p10  <= p10 + ONE;
            end
         end
         if (consume) begin
            case (consume_sel)
               SEL50:   p50 <= p50 - ONE;
               SEL20:   p20 <= p20 - ONE;
               default: p10 <= p10 - ONE;
            endcase
         end
      end
   end

endmodule

// File: rtl/atm_dispense_ctrl.sv
// Cash-dispense sequencer: plans a note breakdown for an authorised amount
// against cassette inventory, then issues notes one at a time over a
// req/ack handshake and reports done or fail. Outputs decode from
// registered state only.
module atm_dispense_ctrl
   import atm_pkg::*;
#(
   parameter int AMT_W = 14,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [AMT_W-1:0] amount,
   input  logic             cancel,
   input  logic             refill,
   input  logic [CNT_W-1:0] refill_cnt,
   output logic             note_req,
   output logic [1:0]       note_sel,
   input  logic             note_ack,
   output logic             busy,
   output logic             done,
   output logic             fail,
   output logic [AMT_W-1:0] dispensed,
   output logic [2:0]       state_display
);

   localparam logic [AMT_W-1:0] D10 = AMT_W'(DEN10);
   localparam logic [AMT_W-1:0] D20 = AMT_W'(DEN20);
   localparam logic [AMT_W-1:0] D50 = AMT_W'(DEN50);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   atm_state_t       state, state_nx;
   logic [CNT_W-1:0] inv50, inv20, inv10;
   logic [CNT_W-1:0] p50, p20, p10;
   logic             plan_ok, plan_fail;
   logic [1:0]       sel;
   logic [AMT_W-1:0] sel_den;
   logic             start_ok;
   logic             ack_ok;

   // A start is taken only in IDLE, loses to refill, and a zero amount fails instead
   assign start_ok = (state == ST_IDLE) && start && !refill && (amount != '0);
   assign ack_ok   = (state == ST_ISSUE) && note_ack;

   atm_note_planner #(
      .AMT_W (AMT_W),
      .CNT_W (CNT_W)
   ) u_planner (
      .clk         (clk),
      .rst         (rst),
      .load        (start_ok),
      .amount      (amount),
      .inv50       (inv50),
      .inv20       (inv20),
      .inv10       (inv10),
      .step        ((state == ST_PLAN) && !cancel),
      .consume     (ack_ok),
      .consume_sel (sel),
      .p50         (p50),
      .p20         (p20),
      .p10         (p10),
      .plan_ok     (plan_ok),
      .plan_fail   (plan_fail)
   );

   // Next note to issue: highest denomination still owed by the plan
   always_comb begin
      sel     = SEL10;
      sel_den = D10;
      if (p50 != '0) begin
         sel     = SEL50;
         sel_den = D50;
      end else if (p20 != '0) begin
         sel     = SEL20;
         sel_den = D20;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: begin
            if (start && !refill) begin
               state_nx = (amount == '0) ? ST_FAIL : ST_PLAN;
            end
         end
         ST_PLAN: begin
            if (cancel) begin
               state_nx = ST_FAIL;
            end else if (plan_ok) begin
               state_nx = ST_ISSUE;
            end else if (plan_fail) begin
               state_nx = ST_FAIL;
            end
         end
         ST_ISSUE: begin
            if (note_ack) begin
               state_nx = ST_GAP;
            end
         end
         ST_GAP: begin
            if ((p50 == '0) && (p20 == '0) && (p10 == '0)) begin
               state_nx = ST_DONE;
            end else begin
               state_nx = ST_ISSUE;
            end
         end
         ST_DONE: state_nx = ST_IDLE;
         ST_FAIL: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // Cassette inventory: bulk load on refill, one note removed per delivery
   always_ff @(posedge clk) begin
      if (rst) begin
         inv50 <= '0;
         inv20 <= '0;
         inv10 <= '0;
      end else if ((state == ST_IDLE) && refill) begin
         inv50 <= refill_cnt;
         inv20 <= refill_cnt;
         inv10 <= refill_cnt;
      end else if (ack_ok) begin
         case (sel)
            SEL50:   inv50 <= inv50 - ONE;
            SEL20:   inv20 <= inv20 - ONE;
            default: inv10 <= inv10 - ONE;
         endcase
      end
   end

   // Running total of delivered cash; cleared only by the next accepted start
   always_ff @(posedge clk) begin
      if (rst) begin
         dispensed <= '0;
      end else if (start_ok) begin
         dispensed <= '0;
      end else if (ack_ok) begin
         dispensed <= dispensed + sel_den;
      end
   end

   assign note_req      = (state == ST_ISSUE);
   assign note_sel      = (state == ST_ISSUE) ? sel : SEL10;
   assign busy          = (state != ST_IDLE);
   assign done          = (state == ST_DONE);
   assign fail          = (state == ST_FAIL);
   assign state_display = state;

endmodule
